// File: rtl/aes_pkg.sv
// Shared types and widths for the AES-256 CTR sequencer.
//   state_t     : sequencer FSM states
//   AES_KEY_W   : AES-256 key width
//   AES_BLK_W   : AES block width
//   TMO_W       : width of the done-wait timeout counter
package aes_pkg;

    localparam int unsigned AES_KEY_W = 256;
    localparam int unsigned AES_BLK_W = 128;
    localparam int unsigned TMO_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEYX  = 3'd1,
        ST_READY = 3'd2,
        ST_ENC   = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

endpackage : aes_pkg

// File: rtl/aes_ctr_sequencer.sv
// CTR-mode controller in front of an AES-256 core: loads the key/IV, runs key
// expansion, then encrypts one counter block per input block and XORs the
// keystream into the data stream.
// Ports:
//   CLK, RST                 clock, async active-high reset
//   key_load, key_in, iv_in  1-cycle load request with key and initial counter
//   key_ready, error         key expanded / sticky timeout flag
//   din_valid/ready, din     input block stream
//   dout_valid/ready, dout   output block stream
//   core_*                   1:1 connection to the AES core
module aes_ctr_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned CTR_WIDTH = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 key_load,
    input  logic [AES_KEY_W-1:0] key_in,
    input  logic [AES_BLK_W-1:0] iv_in,
    output logic                 key_ready,
    output logic                 error,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic [AES_BLK_W-1:0] din,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [AES_BLK_W-1:0] dout,
    output logic                 core_key_start,
    output logic [AES_KEY_W-1:0] core_key,
    output logic                 core_start,
    output logic [AES_BLK_W-1:0] core_plain,
    input  logic [AES_BLK_W-1:0] core_cipher,
    input  logic                 core_finished,
    input  logic                 core_key_finished
);

    // Bits of the counter block that increment; the rest stay as loaded from the IV.
    localparam logic [AES_BLK_W-1:0] CTR_MASK =
        (AES_BLK_W'(1) << CTR_WIDTH) - AES_BLK_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [TMO_W-1:0]     tcnt_q, tcnt_d;
    logic [AES_BLK_W-1:0] ctr_q, ctr_d;
    logic [AES_BLK_W-1:0] din_q, din_q_d;

    logic                 key_ready_d, error_d, din_ready_d, dout_valid_d;
    logic                 core_key_start_d, core_start_d;
    logic [AES_BLK_W-1:0] dout_d, core_plain_d;
    logic [AES_KEY_W-1:0] core_key_d;

    logic                 timeout_hit;
    logic [AES_BLK_W-1:0] ctr_inc;

    // Done on the TIMEOUT-th waiting cycle still wins because it is checked first.
    assign timeout_hit = (tcnt_q == TMO_LAST);
    assign ctr_inc     = (ctr_q & ~CTR_MASK) | ((ctr_q + AES_BLK_W'(1)) & CTR_MASK);

    // Next-state and next-output logic.
    always_comb begin
        state_d          = state_q;
        tcnt_d           = tcnt_q;
        ctr_d            = ctr_q;
        din_q_d          = din_q;
        key_ready_d      = key_ready;
        error_d          = error;
        din_ready_d      = din_ready;
        dout_valid_d     = dout_valid;
        dout_d           = dout;
        core_plain_d     = core_plain;
        core_key_d       = core_key;
        core_key_start_d = 1'b0;
        core_start_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: ;
            ST_KEYX: begin
                if (core_key_finished) begin
                    state_d     = ST_READY;
                    key_ready_d = 1'b1;
                    din_ready_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end
            end
            ST_READY: begin
                if (din_valid && din_ready) begin
                    state_d      = ST_ENC;
                    din_q_d      = din;
                    core_plain_d = ctr_q;
                    core_start_d = 1'b1;
                    din_ready_d  = 1'b0;
                end
            end
            ST_ENC: begin
                if (core_finished) begin
                    state_d      = ST_OUT;
                    dout_d       = din_q ^ core_cipher;
                    dout_valid_d = 1'b1;
                    ctr_d        = ctr_inc;
                end else if (timeout_hit) begin
                    state_d     = ST_IDLE;
                    error_d     = 1'b1;
                    key_ready_d = 1'b0;
                end
            end
            ST_OUT: begin
                if (dout_ready) begin
                    state_d      = ST_READY;
                    dout_valid_d = 1'b0;
                    din_ready_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A key load from any state aborts in-flight work and restarts expansion.
        if (key_load) begin
            state_d          = ST_KEYX;
            core_key_d       = key_in;
            ctr_d            = iv_in;
            core_key_start_d = 1'b1;
            core_start_d     = 1'b0;
            error_d          = 1'b0;
            key_ready_d      = 1'b0;
            din_ready_d      = 1'b0;
            dout_valid_d     = 1'b0;
        end

        // Timeout counter restarts on every state entry, counts only while waiting.
        if (key_load || (state_d != state_q)) begin
            tcnt_d = '0;
        end else if ((state_q == ST_KEYX) || (state_q == ST_ENC)) begin
            tcnt_d = tcnt_q + TMO_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= ST_IDLE;
            tcnt_q         <= '0;
            ctr_q          <= '0;
            din_q          <= '0;
            key_ready      <= 1'b0;
            error          <= 1'b0;
            din_ready      <= 1'b0;
            dout_valid     <= 1'b0;
            dout           <= '0;
            core_plain     <= '0;
            core_key       <= '0;
            core_key_start <= 1'b0;
            core_start     <= 1'b0;
        end else begin
            state_q        <= state_d;
            tcnt_q         <= tcnt_d;
            ctr_q          <= ctr_d;
            din_q          <= din_q_d;
            key_ready      <= key_ready_d;
            error          <= error_d;
            din_ready      <= din_ready_d;
            dout_valid     <= dout_valid_d;
            dout           <= dout_d;
            core_plain     <= core_plain_d;
            core_key       <= core_key_d;
            core_key_start <= core_key_start_d;
            core_start     <= core_start_d;
        end
    end

endmodule : aes_ctr_sequencer

// File: tb/tb_aes_ctr_sequencer.sv
// Bench for aes_ctr_sequencer with a behavioural core stub that returns the
// NIST SP 800-38A F.5.5 keystream for the first two counter blocks.
module tb_aes_ctr_sequencer;
    import aes_pkg::*;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 key_load;
    logic [AES_KEY_W-1:0] key_in;
    logic [AES_BLK_W-1:0] iv_in;
    logic                 key_ready, error, din_valid, din_ready;
    logic [AES_BLK_W-1:0] din, dout;
    logic                 dout_valid, dout_ready;
    logic                 core_key_start, core_start;
    logic [AES_KEY_W-1:0] core_key;
    logic [AES_BLK_W-1:0] core_plain, core_cipher;
    logic                 core_finished, core_key_finished;

    aes_ctr_sequencer #(.CTR_WIDTH(32), .TIMEOUT(255)) dut (
        .CLK(CLK), .RST(RST),
        .key_load(key_load), .key_in(key_in), .iv_in(iv_in),
        .key_ready(key_ready), .error(error),
        .din_valid(din_valid), .din_ready(din_ready), .din(din),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
        .core_key_start(core_key_start), .core_key(core_key),
        .core_start(core_start), .core_plain(core_plain),
        .core_cipher(core_cipher), .core_finished(core_finished),
        .core_key_finished(core_key_finished)
    );

    always #5 CLK = ~CLK;

    localparam logic [AES_KEY_W-1:0] NIST_KEY =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [AES_BLK_W-1:0] IV1  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [AES_BLK_W-1:0] CTR2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    localparam logic [AES_BLK_W-1:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [AES_BLK_W-1:0] C1 = 128'h601ec313775789a5b7a7f504bbf3d228;
    localparam logic [AES_BLK_W-1:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [AES_BLK_W-1:0] C2 = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
    localparam logic [AES_BLK_W-1:0] IVW  = 128'h0123456789abcdef00112233ffffffff;
    localparam logic [AES_BLK_W-1:0] IVW1 = 128'h0123456789abcdef0011223300000000;
    localparam logic [AES_BLK_W-1:0] IVW2 = 128'h0123456789abcdef0011223300000001;

    function automatic logic [AES_BLK_W-1:0] gen_ks(input logic [AES_BLK_W-1:0] c);
        return {c[63:0], c[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
    endfunction

    function automatic logic [AES_BLK_W-1:0] stub_ks(input logic [AES_BLK_W-1:0] p);
        if (p == IV1)  return P1 ^ C1;
        if (p == CTR2) return P2 ^ C2;
        return gen_ks(p);
    endfunction

    // Core stub: fixed latency from start pulse to done pulse.
    int key_lat = 3, enc_lat = 4;
    bit key_en = 1'b1, enc_en = 1'b1;
    int kdly = 0, edly = 0;
    always @(posedge CLK) begin
        core_key_finished <= 1'b0;
        core_finished     <= 1'b0;
        if (core_key_start) kdly <= key_lat;
        else if (kdly > 0) begin
            kdly <= kdly - 1;
            if (kdly == 1 && key_en) core_key_finished <= 1'b1;
        end
        if (core_start) edly <= enc_lat;
        else if (edly > 0) begin
            edly <= edly - 1;
            if (edly == 1 && enc_en) begin
                core_finished <= 1'b1;
                core_cipher   <= stub_ks(core_plain);
            end
        end
    end

    int n_start = 0, n_kstart = 0;
    logic [AES_BLK_W-1:0] plain_at_start = '0;
    always @(posedge CLK) begin
        if (core_start) begin
            n_start        <= n_start + 1;
            plain_at_start <= core_plain;
        end
        if (core_key_start) n_kstart <= n_kstart + 1;
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    function automatic logic sig(input int s);
        case (s)
            0:       return key_ready;
            1:       return din_ready;
            2:       return dout_valid;
            3:       return error;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input string nm, input int s, input int budget, output int waited);
        waited = 0;
        while (!sig(s) && waited < budget) begin
            tick();
            waited++;
        end
        chk(nm, 256'(sig(s)), 256'(1));
    endtask

    task automatic do_key_load(input logic [AES_KEY_W-1:0] k, input logic [AES_BLK_W-1:0] iv);
        int k0, w;
        k0       = n_kstart;
        key_in   = k;
        iv_in    = iv;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        wait_sig("key_ready", 0, 100, w);
        chk("one core_key_start", 256'(n_kstart - k0), 256'(1));
        chk("core_key", 256'(core_key), 256'(k));
    endtask

    task automatic send_block(input logic [AES_BLK_W-1:0] d, input int hold,
                              input logic [AES_BLK_W-1:0] exp_plain,
                              input logic [AES_BLK_W-1:0] exp_dout);
        int s0, w;
        bit stable;
        wait_sig("din_ready", 1, 50, w);
        s0        = n_start;
        din       = d;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        wait_sig("dout_valid", 2, 600, w);
        chk("latency", 256'(w), 256'(enc_lat + 2));
        chk("dout", 256'(dout), 256'(exp_dout));
        chk("core_plain", 256'(plain_at_start), 256'(exp_plain));
        stable = 1'b1;
        repeat (hold) begin
            tick();
            if (dout !== exp_dout || dout_valid !== 1'b1 || din_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) chk("hold stable", 256'(stable), 256'(1));
        chk("core_start count", 256'(n_start - s0), 256'(1));
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        chk("dout_valid drop", 256'(dout_valid), 256'(0));
    endtask

    typedef struct {
        logic [AES_BLK_W-1:0] din;
        int                   hold;
        logic [AES_BLK_W-1:0] exp_plain;
        logic [AES_BLK_W-1:0] exp_dout;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int w, s0, k0;
        bit quiet;
        logic [AES_BLK_W-1:0] c3, c4;
        c3 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01;
        c4 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02;
        vecs[0] = '{P1, 0, IV1, C1};
        vecs[1] = '{P2, 0, CTR2, C2};
        vecs[2] = '{128'h30c81c46a35ce411e5fbc1191a0a52ef, 10, c3,
                    128'h30c81c46a35ce411e5fbc1191a0a52ef ^ gen_ks(c3)};
        vecs[3] = '{128'hf69f2445df4f9b17ad2b417be66c3710, 3, c4,
                    128'hf69f2445df4f9b17ad2b417be66c3710 ^ gen_ks(c4)};

        RST = 1'b1; key_load = 1'b0; key_in = '0; iv_in = '0;
        din_valid = 1'b0; din = '0; dout_ready = 1'b0;
        tick(2);
        chk("reset flags", 256'({key_ready, error, din_ready, dout_valid, core_key_start, core_start}), 256'(0));
        chk("reset dout", 256'(dout), 256'(0));
        RST = 1'b0;
        tick();

        // NIST key load, then the vector table.
        do_key_load(NIST_KEY, IV1);
        for (int i = 0; i < 4; i++)
            send_block(vecs[i].din, vecs[i].hold, vecs[i].exp_plain, vecs[i].exp_dout);

        // key_load together with a din handshake: block not consumed, counter reseeded.
        wait_sig("din_ready pre-collide", 1, 50, w);
        s0 = n_start;
        din = P2; din_valid = 1'b1; key_load = 1'b1; key_in = NIST_KEY; iv_in = IV1;
        tick();
        din_valid = 1'b0; key_load = 1'b0;
        chk("collide din_ready low", 256'(din_ready), 256'(0));
        wait_sig("collide key_ready", 0, 100, w);
        chk("collide no core_start", 256'(n_start - s0), 256'(0));
        send_block(P1, 0, IV1, C1);

        // Counter wrap confined to the low 32 bits.
        do_key_load(NIST_KEY, IVW);
        send_block(P1, 0, IVW, P1 ^ gen_ks(IVW));
        send_block(P2, 0, IVW1, P2 ^ gen_ks(IVW1));

        // Done on the last allowed cycle still succeeds.
        enc_lat = 253;
        send_block(P1, 0, IVW2, P1 ^ gen_ks(IVW2));
        chk("no error at limit", 256'(error), 256'(0));

        // One cycle later is a timeout.
        enc_lat = 254;
        wait_sig("din_ready pre-timeout", 1, 50, w);
        din = P2; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        wait_sig("enc timeout error", 3, 400, w);
        chk("timeout key_ready", 256'(key_ready), 256'(0));
        chk("timeout dout_valid", 256'(dout_valid), 256'(0));
        enc_lat = 4;
        key_in = NIST_KEY; iv_in = IV1; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        chk("key_load clears error", 256'(error), 256'(0));
        wait_sig("key_ready after error", 0, 100, w);

        // Abort mid-ENC: the stale core_finished must be ignored.
        enc_lat = 20;
        wait_sig("din_ready pre-abort", 1, 50, w);
        din = P2; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick(5);
        k0 = n_kstart;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        quiet = 1'b1;
        repeat (40) begin
            tick();
            if (dout_valid !== 1'b0) quiet = 1'b0;
        end
        chk("abort no dout_valid", 256'(quiet), 256'(1));
        chk("abort key_start", 256'(n_kstart - k0), 256'(1));
        chk("abort key_ready", 256'(key_ready), 256'(1));
        enc_lat = 4;
        send_block(P1, 0, IV1, C1);

        // Key expansion timeout.
        key_en = 1'b0;
        key_in = NIST_KEY; iv_in = IV1; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        wait_sig("keyx timeout error", 3, 400, w);
        chk("keyx timeout key_ready", 256'(key_ready), 256'(0));
        key_en = 1'b1;

        // Asynchronous reset while holding a block in OUT.
        do_key_load(NIST_KEY, IV1);
        wait_sig("din_ready pre-rst", 1, 50, w);
        din = P1; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        wait_sig("dout_valid pre-rst", 2, 100, w);
        #2 RST = 1'b1;
        #1;
        chk("rst flags", 256'({key_ready, error, din_ready, dout_valid, core_key_start, core_start}), 256'(0));
        chk("rst dout", 256'(dout), 256'(0));
        chk("rst core_plain", 256'(core_plain), 256'(0));
        chk("rst core_key", 256'(core_key), 256'(0));
        tick();
        RST = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_aes_ctr_sequencer
